pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage, superseding the plain PC register. Holds the fetch PC and presents it to instruction memory through a valid/ready handshake. Advances by ILEN_BYTES on accepted fetches and supports redirects (branch/jump), traps, halt, and misaligned-target detection. Sits between the execute/commit redirect logic and the instruction fetch port.

---
 rtl/pc_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pc_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch-stage program-counter generator. Holds the fetch PC,
//            offers it to instruction memory over a valid/ready handshake,
//            advances by ILEN_BYTES on accepted fetches, and services
//            redirects, traps, halt and misaligned-target detection.
//
// Optional : PCGEN_RAS_EN - when defined, a circular return-address stack of
//            RAS_DEPTH entries is built. Calls (aligned redirect with
//            call_valid) push pc+ILEN_BYTES; returns (accepted fetch with
//            ret_valid) pop into the PC. When undefined, call_valid and
//            ret_valid are ignored and ras_empty is tied high.
//
// Ports    : clk             - clock
//            rst             - synchronous active-high reset
//            fetch_ready     - fetch port accepts the current PC
//            fetch_valid     - PC is a valid fetch request (RUN state only)
//            pc              - current fetch PC
//            pc_next_seq     - pc + ILEN_BYTES (combinational, wraps)
//            redirect_valid  - branch/jump taken this cycle
//            redirect_target - redirect destination
//            trap_valid      - exception/interrupt, go to TRAP_VECTOR
//            halt_req        - stop fetching
//            misalign_fault  - one-cycle pulse after a misaligned redirect
//            fault_addr      - last misaligned target, held until next fault
//            call_valid      - redirect is a call (RAS push)
//            ret_valid       - fetched instruction is a return (RAS pop)
//            ras_empty       - RAS has no entries
//
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int                 D_WIDTH      = 32,
  parameter logic [D_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [D_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int                 ILEN_BYTES   = 4,
  parameter int                 RAS_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [D_WIDTH-1:0] pc,
  output logic [D_WIDTH-1:0] pc_next_seq,
  input  logic               redirect_valid,
  input  logic [D_WIDTH-1:0] redirect_target,
  input  logic               trap_valid,
  input  logic               halt_req,
  output logic               misalign_fault,
  output logic [D_WIDTH-1:0] fault_addr,
  input  logic               call_valid,
  input  logic               ret_valid,
  output logic               ras_empty
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_BOOT = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_HALT = 2'd2;

  localparam logic [D_WIDTH-1:0] c_INC        = D_WIDTH'(ILEN_BYTES);
  // ILEN_BYTES is a power of two, so alignment is a simple low-bit mask.
  localparam logic [D_WIDTH-1:0] c_ALIGN_MASK = D_WIDTH'(ILEN_BYTES - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_fetch_valid;

  logic [D_WIDTH-1:0] r_pc;
  logic [D_WIDTH-1:0] w_pc_nxt;
  logic [D_WIDTH-1:0] w_pc_seq;
  logic               r_fault;
  logic [D_WIDTH-1:0] r_fault_addr;
  logic               w_fault_set;
  logic               w_misalign;
  logic               w_accept;
  logic               w_ras_empty;

  assign w_pc_seq   = r_pc + c_INC;
  assign w_misalign = |(redirect_target & c_ALIGN_MASK);
  assign w_accept   = w_fetch_valid & fetch_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // BOOT always lasts a single cycle; a trap/redirect seen here only
      // changes the PC, the state still moves to RUN.
      c_ST_BOOT: w_state_nxt = c_ST_RUN;
      // Trap/redirect outrank halt: the new target is fetched instead.
      c_ST_RUN: begin
        if (!trap_valid && !redirect_valid && halt_req) begin
          w_state_nxt = c_ST_HALT;
        end
      end
      // halt_req has no effect here; only a new target wakes the fetcher.
      c_ST_HALT: begin
        if (trap_valid || redirect_valid) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      default: w_state_nxt = c_ST_BOOT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_valid = 1'b0;
    if (r_state == c_ST_RUN) begin
      w_fetch_valid = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Return-address stack (optional)
  // --------------------------------------------------------------------------
`ifdef PCGEN_RAS_EN
  localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RAS_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(RAS_DEPTH);

  logic [D_WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  // r_ras_ptr is the next free slot; the top of stack sits one below it.
  logic [c_PTR_W-1:0] r_ras_ptr;
  logic [c_CNT_W-1:0] r_ras_cnt;
  logic [c_PTR_W-1:0] w_ptr_inc;
  logic [c_PTR_W-1:0] w_ptr_dec;
  logic [D_WIDTH-1:0] w_ras_top;
  logic               w_ras_push;
  logic               w_ras_pop;
  logic               w_ras_clear;

  assign w_ptr_inc   = (r_ras_ptr == c_PTR_LAST) ? '0 : r_ras_ptr + c_PTR_W'(1);
  assign w_ptr_dec   = (r_ras_ptr == '0) ? c_PTR_LAST : r_ras_ptr - c_PTR_W'(1);
  assign w_ras_top   = r_ras_mem[w_ptr_dec];
  assign w_ras_empty = (r_ras_cnt == '0);

  // On overflow the pointer keeps wrapping and the count saturates, so the
  // oldest entry is silently overwritten.
  always_ff @(posedge clk) begin
    if (rst || w_ras_clear) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (w_ras_push) begin
      r_ras_ptr <= w_ptr_inc;
      if (r_ras_cnt != c_CNT_FULL) begin
        r_ras_cnt <= r_ras_cnt + c_CNT_W'(1);
      end
    end else if (w_ras_pop) begin
      r_ras_ptr <= w_ptr_dec;
      r_ras_cnt <= r_ras_cnt - c_CNT_W'(1);
    end
  end

  // Storage is not reset: an entry is only read when the count covers it.
  always_ff @(posedge clk) begin
    if (!rst && w_ras_push) begin
      r_ras_mem[r_ras_ptr] <= w_pc_seq;
    end
  end
`else
  assign w_ras_empty = 1'b1;

  logic w_unused;
  assign w_unused = &{1'b0, call_valid, ret_valid, (RAS_DEPTH > 0)};
`endif

  // --------------------------------------------------------------------------
  // Next-PC selection, in priority order: trap, redirect (aligned or
  // misaligned), accepted fetch, hold. Trap/redirect act in every state,
  // which is what lets BOOT and HALT load a new target.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_nxt    = r_pc;
    w_fault_set = 1'b0;
`ifdef PCGEN_RAS_EN
    w_ras_push  = 1'b0;
    w_ras_pop   = 1'b0;
    w_ras_clear = 1'b0;
`endif
    if (trap_valid) begin
      w_pc_nxt = TRAP_VECTOR;
`ifdef PCGEN_RAS_EN
      w_ras_clear = 1'b1;
`endif
    end else if (redirect_valid) begin
      // A redirect is taken even when the current fetch is stalled; the
      // stalled request is simply abandoned.
      if (w_misalign) begin
        w_pc_nxt    = TRAP_VECTOR;
        w_fault_set = 1'b1;
      end else begin
        w_pc_nxt = redirect_target;
`ifdef PCGEN_RAS_EN
        w_ras_push = call_valid;
`endif
      end
    end else if (w_accept) begin
`ifdef PCGEN_RAS_EN
      if (ret_valid && !w_ras_empty) begin
        w_pc_nxt  = w_ras_top;
        w_ras_pop = 1'b1;
      end else begin
        w_pc_nxt = w_pc_seq;
      end
`else
      w_pc_nxt = w_pc_seq;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // PC and fault registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_VECTOR;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_fault <= w_fault_set;
      if (w_fault_set) begin
        r_fault_addr <= redirect_target;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fetch_valid    = w_fetch_valid;
  assign pc             = r_pc;
  assign pc_next_seq    = w_pc_seq;
  assign misalign_fault = r_fault;
  assign fault_addr     = r_fault_addr;
  assign ras_empty      = w_ras_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen. Directed scenarios compare
//            against literal addresses; the random phase compares every
//            output each cycle against a behavioural model of the PC rules
//            (queue-based return stack when PCGEN_RAS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int          IL = 4;
`ifdef PCGEN_RAS_EN
  localparam int          RD = 4;
`endif

  logic          clk             = 1'b0;
  logic          rst             = 1'b1;
  logic          fetch_ready     = 1'b0;
  logic          redirect_valid  = 1'b0;
  logic [DW-1:0] redirect_target = '0;
  logic          trap_valid      = 1'b0;
  logic          halt_req        = 1'b0;
  logic          call_valid      = 1'b0;
  logic          ret_valid       = 1'b0;
  logic          fetch_valid;
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_next_seq;
  logic          misalign_fault;
  logic [DW-1:0] fault_addr;
  logic          ras_empty;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .D_WIDTH     (DW),
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV),
    .ILEN_BYTES  (IL),
    .RAS_DEPTH   (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .pc_next_seq    (pc_next_seq),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .halt_req       (halt_req),
    .misalign_fault (misalign_fault),
    .fault_addr     (fault_addr),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .ras_empty      (ras_empty)
  );

  // --------------------------------------------------------------------------
  // Reference model: m_st 0 = booting, 1 = running, 2 = halted
  // --------------------------------------------------------------------------
  logic [31:0] m_pc    = RV;
  int          m_st    = 0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = '0;
`ifdef PCGEN_RAS_EN
  logic [31:0] m_ras[$];
`endif

  task automatic model_step();
    logic [31:0] npc;
    int          nst;
    logic        nfault;
    if (rst) begin
      m_pc = RV; m_st = 0; m_fault = 1'b0; m_faddr = '0;
`ifdef PCGEN_RAS_EN
      m_ras.delete();
`endif
      return;
    end
    npc = m_pc; nst = m_st; nfault = 1'b0;
    if (trap_valid) begin
      npc = TV; nst = 1;
`ifdef PCGEN_RAS_EN
      m_ras.delete();
`endif
    end else if (redirect_valid) begin
      nst = 1;
      if ((redirect_target % IL) != 0) begin
        npc = TV; nfault = 1'b1; m_faddr = redirect_target;
      end else begin
        npc = redirect_target;
`ifdef PCGEN_RAS_EN
        if (call_valid) begin
          m_ras.push_back(m_pc + IL);
          if (m_ras.size() > RD) void'(m_ras.pop_front());
        end
`endif
      end
    end else if (m_st == 0) begin
      nst = 1;
    end else if (m_st == 1) begin
      if (fetch_ready) begin
        npc = m_pc + IL;
`ifdef PCGEN_RAS_EN
        if (ret_valid && m_ras.size() > 0) npc = m_ras.pop_back();
`endif
      end
      if (halt_req) nst = 2;
    end
    m_pc = npc; m_st = nst; m_fault = nfault;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; halt_req = 1'b0; call_valid = 1'b0; ret_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h300;
    repeat (3) step();
    n_checks++; if (pc !== RV) $display("FAIL reset_pc: got %h want %h", pc, RV); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", fetch_valid); else n_pass++;
    n_checks++; if (misalign_fault !== 1'b0) $display("FAIL reset_mf: got %b want 0", misalign_fault); else n_pass++;
    n_checks++; if (fault_addr !== 32'h0) $display("FAIL reset_faddr: got %h want 0", fault_addr); else n_pass++;
    n_checks++; if (ras_empty !== 1'b1) $display("FAIL reset_ras_empty: got %b want 1", ras_empty); else n_pass++;
    rst = 1'b0; redirect_valid = 1'b0;
    // BOOT cycle: no request yet
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL boot_fv: got %b want 0", fetch_valid); else n_pass++;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pc !== 32'(i * 4)) $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(i * 4)); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b1) $display("FAIL seq_fv[%0d]: got %b want 1", i, fetch_valid); else n_pass++;
      step();
    end
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1; redirect_target = 32'h8; fetch_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got pc %h fv %b want pc 8 fv 1", i, pc, fetch_valid); else n_pass++;
      step();
    end
    fetch_ready = 1'b1;
    step();
    n_checks++; if (pc !== 32'hC) $display("FAIL stall_release: got %h want c", pc); else n_pass++;
  endtask

  task automatic test_redirect_trap();
    redirect_valid = 1'b1; redirect_target = 32'h10; fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0; redirect_target = 32'h200;
    step();
    n_checks++; if (pc !== 32'h200) $display("FAIL redirect_stalled: got %h want 200", pc); else n_pass++;
    redirect_target = 32'h10;
    step();
    redirect_target = 32'h200; trap_valid = 1'b1;
    step();
    n_checks++; if (pc !== TV) $display("FAIL trap_over_redirect: got %h want %h", pc, TV); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b1) $display("FAIL trap_fv: got %b want 1", fetch_valid); else n_pass++;
    redirect_valid = 1'b0; trap_valid = 1'b0;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h202; fetch_ready = 1'b1;
    step();
    n_checks++; if (pc !== TV || misalign_fault !== 1'b1 || fault_addr !== 32'h202)
      $display("FAIL misalign: got pc %h mf %b fa %h want 100 1 202", pc, misalign_fault, fault_addr); else n_pass++;
    redirect_valid = 1'b0; fetch_ready = 1'b0;
    step();
    n_checks++; if (misalign_fault !== 1'b0 || fault_addr !== 32'h202 || pc !== TV)
      $display("FAIL misalign_pulse_end: got pc %h mf %b fa %h want 100 0 202", pc, misalign_fault, fault_addr); else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'h206;
    step();
    n_checks++; if (misalign_fault !== 1'b1 || fault_addr !== 32'h206)
      $display("FAIL misalign_b2b1: got mf %b fa %h want 1 206", misalign_fault, fault_addr); else n_pass++;
    redirect_target = 32'h20B;
    step();
    n_checks++; if (misalign_fault !== 1'b1 || fault_addr !== 32'h20B)
      $display("FAIL misalign_b2b2: got mf %b fa %h want 1 20b", misalign_fault, fault_addr); else n_pass++;
    // Trap outranks a misaligned redirect: no fault recorded.
    redirect_target = 32'h301; trap_valid = 1'b1;
    step();
    n_checks++; if (misalign_fault !== 1'b0 || fault_addr !== 32'h20B || pc !== TV)
      $display("FAIL misalign_trap: got pc %h mf %b fa %h want 100 0 20b", pc, misalign_fault, fault_addr); else n_pass++;
    redirect_valid = 1'b0; trap_valid = 1'b0;
  endtask

  task automatic test_halt_wrap();
    redirect_valid = 1'b1; redirect_target = 32'h20; fetch_ready = 1'b0;
    step();
    redirect_valid = 1'b0; halt_req = 1'b1;
    step();
    fetch_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (fetch_valid !== 1'b0 || pc !== 32'h20)
        $display("FAIL halt_hold[%0d]: got fv %b pc %h want 0 20", i, fetch_valid, pc); else n_pass++;
      step();
    end
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'h40 || fetch_valid !== 1'b1)
      $display("FAIL halt_wake: got pc %h fv %b want 40 1", pc, fetch_valid); else n_pass++;
    // Accepted fetch in the halting cycle still advances.
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n_checks++; if (pc !== 32'h44 || fetch_valid !== 1'b0)
      $display("FAIL halt_accept: got pc %h fv %b want 44 0", pc, fetch_valid); else n_pass++;
    trap_valid = 1'b1;
    step();
    trap_valid = 1'b0;
    n_checks++; if (pc !== TV || fetch_valid !== 1'b1)
      $display("FAIL halt_trap_wake: got pc %h fv %b want 100 1", pc, fetch_valid); else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc_next_seq !== 32'h0) $display("FAIL wrap_next_seq: got %h want 0", pc_next_seq); else n_pass++;
    step();
    n_checks++; if (pc !== 32'h0 || misalign_fault !== 1'b0)
      $display("FAIL wrap: got pc %h mf %b want 0 0", pc, misalign_fault); else n_pass++;
  endtask

  task automatic test_ras();
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h30;
    step();
    call_valid = 1'b1; redirect_target = 32'h400;
    step();
    redirect_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b1; fetch_ready = 1'b1;
`ifdef PCGEN_RAS_EN
    n_checks++; if (pc !== 32'h400 || ras_empty !== 1'b0)
      $display("FAIL ras_call: got pc %h re %b want 400 0", pc, ras_empty); else n_pass++;
    step();
    n_checks++; if (pc !== 32'h34 || ras_empty !== 1'b1)
      $display("FAIL ras_ret: got pc %h re %b want 34 1", pc, ras_empty); else n_pass++;
    ret_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1000;
    step();
    call_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      redirect_target = 32'((k + 1) * 32'h1000);
      step();
    end
    redirect_valid = 1'b0; call_valid = 1'b0; ret_valid = 1'b1;
    for (int k = 5; k >= 2; k--) begin
      step();
      n_checks++; if (pc !== 32'(k * 32'h1000 + 4))
        $display("FAIL ras_lifo[%0d]: got %h want %h", k, pc, 32'(k * 32'h1000 + 4)); else n_pass++;
    end
    n_checks++; if (ras_empty !== 1'b1) $display("FAIL ras_drained: got %b want 1", ras_empty); else n_pass++;
    step();
    n_checks++; if (pc !== 32'h2008) $display("FAIL ras_empty_ret: got %h want 2008", pc); else n_pass++;
    ret_valid = 1'b0; redirect_valid = 1'b1; call_valid = 1'b1; redirect_target = 32'h800;
    step();
    redirect_valid = 1'b0; call_valid = 1'b0; trap_valid = 1'b1;
    step();
    trap_valid = 1'b0;
    n_checks++; if (ras_empty !== 1'b1 || pc !== TV)
      $display("FAIL ras_trap_clear: got re %b pc %h want 1 100", ras_empty, pc); else n_pass++;
`else
    n_checks++; if (pc !== 32'h400 || ras_empty !== 1'b1)
      $display("FAIL noras_call: got pc %h re %b want 400 1", pc, ras_empty); else n_pass++;
    step();
    n_checks++; if (pc !== 32'h404) $display("FAIL noras_ret: got %h want 404", pc); else n_pass++;
`endif
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h500;
    trap_valid = 1'b1; halt_req = 1'b1;
    step();
    n_checks++; if (pc !== RV || fetch_valid !== 1'b0 || fault_addr !== 32'h0)
      $display("FAIL mid_reset: got pc %h fv %b fa %h want 0 0 0", pc, fetch_valid, fault_addr); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    logic        exp_fv;
    logic        exp_re;
    logic [31:0] exp_seq;
    for (int i = 0; i < 800; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      trap_valid     = ($urandom_range(0, 29) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_target = {16'h0, 16'($urandom_range(0, 16'hFFFF))};
      if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
      halt_req       = ($urandom_range(0, 19) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      call_valid     = ($urandom_range(0, 1) == 0);
      ret_valid      = ($urandom_range(0, 2) == 0);
      step();
      exp_fv  = (m_st == 1);
      exp_seq = m_pc + IL;
`ifdef PCGEN_RAS_EN
      exp_re  = (m_ras.size() == 0);
`else
      exp_re  = 1'b1;
`endif
      n_checks++; if (pc !== m_pc) $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, m_pc); else n_pass++;
      n_checks++; if (fetch_valid !== exp_fv) $display("FAIL rand_fv[%0d]: got %b want %b", i, fetch_valid, exp_fv); else n_pass++;
      n_checks++; if (misalign_fault !== m_fault) $display("FAIL rand_mf[%0d]: got %b want %b", i, misalign_fault, m_fault); else n_pass++;
      n_checks++; if (fault_addr !== m_faddr) $display("FAIL rand_fa[%0d]: got %h want %h", i, fault_addr, m_faddr); else n_pass++;
      n_checks++; if (ras_empty !== exp_re) $display("FAIL rand_re[%0d]: got %b want %b", i, ras_empty, exp_re); else n_pass++;
      n_checks++; if (pc_next_seq !== exp_seq) $display("FAIL rand_seq[%0d]: got %h want %h", i, pc_next_seq, exp_seq); else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_trap();
    test_misalign();
    test_halt_wrap();
    test_ras();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
